hack_mem_arbiter: RTL and testbench

- Shares the single Hack memory port (RAM16K 0x0000-0x3FFF, screen 0x4000-0x5FFF, keyboard 0x6000) between the Hack CPU and one DMA requester, e.g. a MiSTer ioctl loader or an HPS debug port.
- CPU has priority; a bounded-wait counter guarantees DMA progress by stalling the CPU.
- Sits between the CPU/DMA masters and the Memory block.
- Drives that block's address/in/load inputs and returns its out word.

---
 rtl/hack_mem_pkg.sv | 32 +++
 rtl/hack_screen_clear.sv | 69 ++++++
 rtl/hack_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_hack_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg
//   Shared definitions for the Hack memory arbiter slice: memory map
//   constants, the region-select field of a word address and the bus
//   ownership enum.
//   Optional feature macro used by the importing files: HACK_SCREEN_CLEAR_EN.
package hack_mem_pkg;

  // Hack memory map (word addresses, 15 bits)
  localparam logic [14:0] RAM_BASE     = 15'h0000;
  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam int          SCREEN_WORDS = 8192;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;

  // Address bits [14:13] select the region; 2'b11 is the keyboard window
  localparam int          REGION_HI  = 14;
  localparam int          REGION_LO  = 13;
  localparam logic [1:0]  REGION_KBD = KBD_ADDR[REGION_HI:REGION_LO];

  // Who drives the Memory block this cycle
  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CPU,
    OWN_DMA,
    OWN_CLEAR
  } owner_e;

  // True when a word address falls in the keyboard window
  function automatic logic is_kbd_region(input logic [14:0] addr);
    return addr[REGION_HI:REGION_LO] == REGION_KBD;
  endfunction

endpackage

// File: rtl/hack_screen_clear.sv
// hack_screen_clear
//   Screen-clear engine: walks the screen region one word per cycle and
//   asks the arbiter to write 0 there. Only instantiated when
//   HACK_SCREEN_CLEAR_EN is defined.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   start  in   pulse, start a clear (ignored while busy)
//   addr   out  screen word address to write this cycle
//   busy   out  clear in progress
//   wr     out  write request to the arbiter this cycle
module hack_screen_clear
  import hack_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [14:0] addr,
  output logic        busy,
  output logic        wr
);

  typedef enum logic {IDLE, RUN} clr_state_e;

  clr_state_e  state;
  logic [13:0] cnt;
  logic        boot;

  localparam logic [13:0] LAST_OFFSET = 14'(SCREEN_WORDS - 1);

  // The engine runs once automatically on the first clock after reset
  // release (boot), and again for every start pulse seen while idle.
  // The 14-bit offset counter runs 0x0000..0x1FFF, i.e. addresses
  // 0x4000..0x5FFF; busy drops the cycle after the last write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      boot  <= 1'b1;
      busy  <= 1'b0;
      wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (boot || start) begin
            state <= RUN;
            cnt   <= '0;
            boot  <= 1'b0;
            busy  <= 1'b1;
            wr    <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == LAST_OFFSET) begin
            state <= IDLE;
            busy  <= 1'b0;
            wr    <= 1'b0;
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign addr = SCREEN_BASE + {1'b0, cnt};

endmodule

// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter
//   Shares the single Hack Memory port between the CPU and one DMA master.
//   The CPU has priority, but a DMA request that has lost MAX_WAIT
//   consecutive cycles stalls the CPU for one cycle and gets the bus.
//   DMA writes into the keyboard window are dropped and flagged on dma_err.
//   Optional feature macro: HACK_SCREEN_CLEAR_EN (screen-clear engine that
//   zeroes 0x4000..0x5FFF after reset and on clear_start).
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_addr/cpu_in/cpu_load  CPU access; cpu_out read data,
//                                     cpu_stall holds the CPU
//   dma_req/dma_we/dma_addr/dma_wdata DMA request; dma_gnt accept,
//                                     dma_rdata/dma_rvalid read return,
//                                     dma_err dropped keyboard write
//   clear_start/clear_busy            screen clear control/status
//   mem_addr/mem_in/mem_load/mem_out  Memory block port
module hack_mem_arbiter
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_in,
  input  logic              cpu_load,
  output logic [DATA_W-1:0] cpu_out,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_err,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  owner_e      owner;
  owner_e      bus_owner;
  logic [3:0]  wait_cnt;
  logic        dma_kbd;
  logic        clear_active;
  logic [14:0] clear_addr;

`ifdef HACK_SCREEN_CLEAR_EN
  logic clear_busy_w;

  hack_screen_clear u_clear (
    .clk   (clk),
    .reset (reset),
    .start (clear_start),
    .addr  (clear_addr),
    .busy  (clear_busy_w),
    .wr    (clear_active)
  );

  assign clear_busy = clear_busy_w;
`else
  logic unused_clear_start;

  assign unused_clear_start = clear_start;
  assign clear_active       = 1'b0;
  assign clear_addr         = '0;
  assign clear_busy         = 1'b0;
`endif

  assign dma_kbd = is_kbd_region(dma_addr[14:0]);
  assign cpu_out = mem_out;

  // Ownership for the registered state. Reset is applied separately on
  // the output path so the flops never see reset as a data input.
  always_comb begin
    owner = OWN_IDLE;
    if (clear_active) begin
      owner = OWN_CLEAR;
    end else if (cpu_req && (!dma_req || (wait_cnt < MAX_WAIT_C))) begin
      owner = OWN_CPU;
    end else if (dma_req) begin
      owner = OWN_DMA;
    end
  end

  // While reset is asserted every request is treated as absent
  assign bus_owner = reset ? owner : OWN_IDLE;

  // Memory port and handshake outputs for the current owner. IDLE keeps
  // the CPU address on the bus so the read path stays quiet.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_in    = '0;
    mem_load  = 1'b0;
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    case (bus_owner)
      OWN_CPU: begin
        mem_in   = cpu_in;
        mem_load = cpu_load;
      end
      OWN_DMA: begin
        mem_addr  = dma_addr;
        mem_in    = dma_wdata;
        mem_load  = dma_we && !dma_kbd;
        dma_gnt   = 1'b1;
        cpu_stall = cpu_req;
      end
      OWN_CLEAR: begin
        mem_addr  = ADDR_W'(clear_addr);
        mem_load  = 1'b1;
        cpu_stall = cpu_req;
      end
      default: ;
    endcase
  end

  // Fairness counter plus the registered DMA return path. wait_cnt counts
  // cycles a pending DMA lost to the CPU and saturates at MAX_WAIT, at
  // which point the CPU no longer wins; a grant resets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= '0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_err    <= 1'b0;
    end else begin
      dma_rvalid <= (owner == OWN_DMA) && !dma_we;
      dma_err    <= (owner == OWN_DMA) && dma_we && dma_kbd;
      if ((owner == OWN_DMA) && !dma_we) begin
        dma_rdata <= mem_out;
      end
      case (owner)
        OWN_CPU: begin
          if (dma_req && (wait_cnt < MAX_WAIT_C)) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        OWN_DMA: wait_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// tb_hack_mem_arbiter
//   Self-checking bench for hack_mem_arbiter. A behavioural Memory block
//   sits on the mem_* port; a reference model built from the arbitration
//   rules predicts every output, compared on every falling edge, and
//   directed sequences add literal expectations for the key scenarios.
//   Honours HACK_SCREEN_CLEAR_EN when defined.
module tb_hack_mem_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_in;
  logic              cpu_load;
  logic [DATA_W-1:0] cpu_out;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_err;
  logic              clear_start;
  logic              clear_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  int n_checks = 0;
  int n_pass   = 0;

  hack_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_in      (cpu_in),
    .cpu_load    (cpu_load),
    .cpu_out     (cpu_out),
    .cpu_stall   (cpu_stall),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_gnt     (dma_gnt),
    .dma_rdata   (dma_rdata),
    .dma_rvalid  (dma_rvalid),
    .dma_err     (dma_err),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .mem_addr    (mem_addr),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Hack Memory: RAM and screen are writable, the keyboard
  // and anything above reads 0 and ignores writes
  logic [DATA_W-1:0] mem [0:32767];
  assign mem_out = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_load && (mem_addr < 15'h6000)) mem[mem_addr] <= mem_in;
  end

  // Reference model state
  int                m_wait;
  bit                m_rvalid;
  bit                m_err;
  logic [DATA_W-1:0] m_rdata;
  int                m_clear_left;
  logic [ADDR_W-1:0] m_clear_addr;
  bit                m_boot;
  logic [DATA_W-1:0] shadow [0:32767];
  bit                cmp_en = 1'b0;

  // 0 idle, 1 cpu, 2 dma, 3 clear
  function automatic int model_owner();
    if (!reset) return 0;
    if (m_clear_left > 0) return 3;
    if (cpu_req && (!dma_req || m_wait < MAX_WAIT)) return 1;
    if (dma_req) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    int own;
    if (!reset) begin
      m_wait       = 0;
      m_rvalid     = 1'b0;
      m_err        = 1'b0;
      m_rdata      = '0;
      m_clear_left = 0;
      m_boot       = 1'b1;
    end else begin
      own      = model_owner();
      m_rvalid = (own == 2) && !dma_we;
      m_err    = (own == 2) && dma_we && (dma_addr >= 15'h6000);
      if ((own == 2) && !dma_we) m_rdata = shadow[dma_addr];
      if ((own == 1) && cpu_load && (cpu_addr < 15'h6000)) shadow[cpu_addr] = cpu_in;
      if ((own == 2) && dma_we && (dma_addr < 15'h6000)) shadow[dma_addr] = dma_wdata;
      if (own == 3) shadow[m_clear_addr] = '0;
      if ((own == 1) && dma_req) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      if (own == 2) m_wait = 0;
`ifdef HACK_SCREEN_CLEAR_EN
      if (m_clear_left > 0) begin
        m_clear_addr = m_clear_addr + 1'b1;
        m_clear_left = m_clear_left - 1;
      end else if (m_boot || clear_start) begin
        m_clear_left = 8192;
        m_clear_addr = 15'h4000;
      end
      m_boot = 1'b0;
`endif
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Continuous comparison against the model
  always @(negedge clk) begin
    int own;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_in;
    logic              e_load;
    if (cmp_en) begin
      own    = model_owner();
      e_addr = (own == 2) ? dma_addr : (own == 3) ? m_clear_addr : cpu_addr;
      e_in   = (own == 1) ? cpu_in : (own == 2) ? dma_wdata : '0;
      e_load = (own == 1) ? cpu_load :
               (own == 2) ? (dma_we && (dma_addr < 15'h6000)) :
               (own == 3);
      check_output("mdl_mem_addr", 32'(mem_addr), 32'(e_addr));
      check_output("mdl_mem_in", 32'(mem_in), 32'(e_in));
      check_output("mdl_mem_load", 32'(mem_load), 32'(e_load));
      check_output("mdl_cpu_stall", 32'(cpu_stall), 32'(((own == 2) || (own == 3)) && cpu_req));
      check_output("mdl_dma_gnt", 32'(dma_gnt), 32'(own == 2));
      check_output("mdl_dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
      check_output("mdl_dma_rdata", 32'(dma_rdata), 32'(m_rdata));
      check_output("mdl_dma_err", 32'(dma_err), 32'(m_err));
      check_output("mdl_clear_busy", 32'(clear_busy), 32'(m_clear_left > 0));
      if (own == 1) check_output("mdl_cpu_out", 32'(cpu_out), 32'(shadow[cpu_addr]));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic c_req, input logic [14:0] c_addr,
                                input logic [15:0] c_in, input logic c_load,
                                input logic d_req, input logic d_we,
                                input logic [14:0] d_addr, input logic [15:0] d_wdata,
                                input logic clr);
    cpu_req     = c_req;
    cpu_addr    = c_addr;
    cpu_in      = c_in;
    cpu_load    = c_load;
    dma_req     = d_req;
    dma_we      = d_we;
    dma_addr    = d_addr;
    dma_wdata   = d_wdata;
    clear_start = clr;
  endtask

  task automatic go_idle();
    apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
  endtask

  // After reset release the clear engine (when built) owns the bus for a
  // full screen pass; the model tells us when it has finished
  task automatic wait_clear_done();
`ifdef HACK_SCREEN_CLEAR_EN
    next_cycle();
    while (m_clear_left > 0) next_cycle();
`endif
  endtask

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    m_wait = 0; m_rvalid = 0; m_err = 0; m_rdata = '0;
    m_clear_left = 0; m_clear_addr = '0; m_boot = 1'b1;
    reset = 1'b0;
    apply_stimulus(1'b1, 15'h0010, 16'h5555, 1'b1, 1'b1, 1'b1, 15'h0010, 16'h1111, 1'b0);
    cmp_en = 1'b1;

    // Reset state: requests present but ignored
    @(negedge clk);
    check_output("rst_gnt", 32'(dma_gnt), 32'h0);
    check_output("rst_stall", 32'(cpu_stall), 32'h0);
    check_output("rst_load", 32'(mem_load), 32'h0);
    check_output("rst_rvalid", 32'(dma_rvalid), 32'h0);
    check_output("rst_rdata", 32'(dma_rdata), 32'h0);
    check_output("rst_err", 32'(dma_err), 32'h0);
    check_output("rst_busy", 32'(clear_busy), 32'h0);

    next_cycle();
    go_idle();
    reset = 1'b1;
    wait_clear_done();

    // DMA write then back-to-back read of the same word
    next_cycle();
    apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b1, 15'h0010, 16'hBEEF, 1'b0);
    @(negedge clk);
    check_output("dma_wr_gnt", 32'(dma_gnt), 32'h1);
    check_output("dma_wr_load", 32'(mem_load), 32'h1);
    check_output("dma_wr_addr", 32'(mem_addr), 32'h0010);
    check_output("dma_wr_data", 32'(mem_in), 32'hBEEF);
    next_cycle();
    apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0);
    @(negedge clk);
    check_output("dma_rd_gnt", 32'(dma_gnt), 32'h1);
    check_output("dma_rd_load", 32'(mem_load), 32'h0);
    next_cycle();
    go_idle();
    @(negedge clk);
    check_output("dma_rd_rvalid", 32'(dma_rvalid), 32'h1);
    check_output("dma_rd_rdata", 32'(dma_rdata), 32'hBEEF);
    next_cycle();
    @(negedge clk);
    check_output("dma_rd_pulse", 32'(dma_rvalid), 32'h0);

    // Contention: DMA must win exactly every 5th cycle
    for (int i = 1; i <= 15; i++) begin
      next_cycle();
      apply_stimulus(1'b1, 15'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0);
      @(negedge clk);
      check_output($sformatf("cont_gnt_%0d", i), 32'(dma_gnt), 32'((i % 5) == 0));
      check_output($sformatf("cont_stall_%0d", i), 32'(cpu_stall), 32'((i % 5) == 0));
      if (i == 1) check_output("cont_cpu_out", 32'(cpu_out), 32'hBEEF);
    end
    next_cycle();
    go_idle();

    // DMA write into the keyboard window is dropped and flagged
    next_cycle();
    apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b1, 15'h6000, 16'hAAAA, 1'b0);
    @(negedge clk);
    check_output("kbd_gnt", 32'(dma_gnt), 32'h1);
    check_output("kbd_load", 32'(mem_load), 32'h0);
    next_cycle();
    go_idle();
    @(negedge clk);
    check_output("kbd_err", 32'(dma_err), 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 15'h6000, 16'h0, 1'b0);
    @(negedge clk);
    check_output("kbd_err_pulse", 32'(dma_err), 32'h0);
    next_cycle();
    go_idle();
    @(negedge clk);
    check_output("kbd_rdata", 32'(dma_rdata), 32'h0000);

    // CPU write, read back through DMA
    next_cycle();
    apply_stimulus(1'b1, 15'h0020, 16'h1234, 1'b1, 1'b0, 1'b0, 15'h0, 16'h0, 1'b0);
    @(negedge clk);
    check_output("cpu_wr_load", 32'(mem_load), 32'h1);
    check_output("cpu_wr_stall", 32'(cpu_stall), 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 15'h0020, 16'h0, 1'b0);
    next_cycle();
    go_idle();
    @(negedge clk);
    check_output("cpu_wr_rdback", 32'(dma_rdata), 32'h1234);

    // Reset while DMA is pending with wait_cnt = 3
    next_cycle();
    apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      apply_stimulus(1'b1, 15'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 15'h0010, 16'h0, 1'b0);
    end
    next_cycle();
    check_output("pre_rst_rdata", 32'(dma_rdata), 32'hBEEF);
    reset = 1'b0;
    #1;
    check_output("mid_rst_rdata", 32'(dma_rdata), 32'h0);
    check_output("mid_rst_rvalid", 32'(dma_rvalid), 32'h0);
    check_output("mid_rst_err", 32'(dma_err), 32'h0);
    check_output("mid_rst_gnt", 32'(dma_gnt), 32'h0);
    check_output("mid_rst_stall", 32'(cpu_stall), 32'h0);
    next_cycle();
    reset = 1'b1;
    wait_clear_done();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_output($sformatf("post_rst_gnt_%0d", i), 32'(dma_gnt), 32'(i == 5));
      check_output($sformatf("post_rst_stall_%0d", i), 32'(cpu_stall), 32'(i == 5));
      next_cycle();
    end
    go_idle();

`ifdef HACK_SCREEN_CLEAR_EN
    begin
      int busy_cycles;
      next_cycle();
      apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b1, 15'h4000, 16'hFFFF, 1'b0);
      next_cycle();
      apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b1, 15'h5FFF, 16'h1234, 1'b0);
      next_cycle();
      apply_stimulus(1'b1, 15'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1);
      next_cycle();
      clear_start = 1'b0;
      busy_cycles = 0;
      while (clear_busy && busy_cycles < 9000) begin
        busy_cycles++;
        next_cycle();
      end
      check_output("clr_busy_cycles", 32'(busy_cycles), 32'd8192);
      go_idle();
      apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 15'h4000, 16'h0, 1'b0);
      next_cycle();
      apply_stimulus(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 15'h5FFF, 16'h0, 1'b0);
      @(negedge clk);
      check_output("clr_rd_4000", 32'(dma_rdata), 32'h0);
      next_cycle();
      go_idle();
      @(negedge clk);
      check_output("clr_rd_5fff", 32'(dma_rdata), 32'h0);
    end
`else
    next_cycle();
    apply_stimulus(1'b1, 15'h0100, 16'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 1'b1);
    next_cycle();
    clear_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("noclr_busy_%0d", i), 32'(clear_busy), 32'h0);
      check_output($sformatf("noclr_stall_%0d", i), 32'(cpu_stall), 32'h0);
      next_cycle();
    end
    go_idle();
`endif

    next_cycle();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
